// File: rtl/uart_rx_os_if.sv
// Host-side result bus of the oversampling UART receiver.
// The receiver drives it through the master modport; host logic reads it through slave.
interface uart_rx_os_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 par_err;
    logic                 frm_err;
    logic                 busy;

    modport master (
        output data_out,
        output data_valid,
        output par_err,
        output frm_err,
        output busy
    );

    modport slave (
        input data_out,
        input data_valid,
        input par_err,
        input frm_err,
        input busy
    );
endinterface

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: start-bit validation at mid-bit, LSB-first data, optional parity,
// stop check, and a one-cycle valid strobe. All decisions are taken only on baud ticks.
module uart_rx_os #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick,
    input  logic            rx,
    input  logic            par_en,
    input  logic            par_odd,
    uart_rx_os_if.master    host
);

    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StStart    = 3'd1;
    localparam logic [2:0] StData     = 3'd2;
    localparam logic [2:0] StParity   = 3'd3;
    localparam logic [2:0] StStop     = 3'd4;
    localparam logic [2:0] StWaitHigh = 3'd5;

    logic                 rx_m_q, rx_s_q;
    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bitn_q, bitn_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 par_en_q, par_en_d;
    logic                 par_odd_q, par_odd_d;
    logic                 perr_q, perr_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 data_valid_q, data_valid_d;
    logic                 par_err_q, par_err_d;
    logic                 frm_err_q, frm_err_d;

    // Idle-high line, so the synchroniser resets to 1 to avoid a false start after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m_q <= 1'b1;
            rx_s_q <= 1'b1;
        end else begin
            rx_m_q <= rx;
            rx_s_q <= rx_m_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bitn_d       = bitn_q;
        sh_d         = sh_q;
        par_en_d     = par_en_q;
        par_odd_d    = par_odd_q;
        perr_d       = perr_q;
        data_out_d   = data_out_q;
        par_err_d    = par_err_q;
        frm_err_d    = frm_err_q;
        data_valid_d = 1'b0;

        if (tick) begin
            case (state_q)
                StIdle: begin
                    if (!rx_s_q) begin
                        state_d   = StStart;
                        cnt_d     = '0;
                        par_en_d  = par_en;
                        par_odd_d = par_odd;
                    end
                end
                StStart: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_d  = '0;
                        bitn_d = '0;
                        // A line that is high again at mid start bit was only a glitch.
                        state_d = rx_s_q ? StIdle : StData;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d  = '0;
                        bitn_d = bitn_q + 1'b1;
                        sh_d   = {rx_s_q, sh_q[DATA_BITS-1:1]};
                        if (bitn_q == BIT_LAST) begin
                            state_d = par_en_q ? StParity : StStop;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StParity: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        perr_d  = rx_s_q ^ (^sh_q) ^ par_odd_q;
                        state_d = StStop;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d        = '0;
                        data_out_d   = sh_q;
                        frm_err_d    = ~rx_s_q;
                        par_err_d    = par_en_q & perr_q;
                        data_valid_d = 1'b1;
                        state_d      = rx_s_q ? StIdle : StWaitHigh;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StWaitHigh: begin
                    if (rx_s_q) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            bitn_q       <= '0;
            sh_q         <= '0;
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
            perr_q       <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            frm_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bitn_q       <= bitn_d;
            sh_q         <= sh_d;
            par_en_q     <= par_en_d;
            par_odd_q    <= par_odd_d;
            perr_q       <= perr_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            frm_err_q    <= frm_err_d;
        end
    end

    assign host.data_out   = data_out_q;
    assign host.data_valid = data_valid_q;
    assign host.par_err    = par_err_q;
    assign host.frm_err    = frm_err_q;
    assign host.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed and randomized frames for uart_rx_os; expected words and flags come from a
// frame-level model of the serial protocol, compared against every observed valid strobe.
module tb_uart_rx_os;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned DIV        = 4;
    localparam int unsigned BIT_CLK    = DIV * OVERSAMPLE;

    typedef struct {
        logic [DATA_BITS-1:0] d;
        logic                 pe;
        logic                 fe;
    } frame_t;

    logic clk     = 1'b0;
    logic rst     = 1'b0;
    logic tick    = 1'b0;
    logic rx      = 1'b1;
    logic par_en  = 1'b0;
    logic par_odd = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic prev_dv = 1'b0;

    frame_t exp_q[$];
    frame_t got_q[$];
    int     got_t[$];

    uart_rx_os_if #(.DATA_BITS(DATA_BITS)) host ();

    uart_rx_os #(
        .DATA_BITS (DATA_BITS),
        .OVERSAMPLE(OVERSAMPLE)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .rx     (rx),
        .par_en (par_en),
        .par_odd(par_odd),
        .host   (host)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Baud generator: one-clk tick every DIV clocks.
    initial begin
        forever begin
            repeat (DIV - 1) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Collect every valid strobe; a strobe must never last two cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (host.data_valid === 1'b1) begin
                check("dv_one_cycle", 32'(prev_dv), 32'd0);
                got_q.push_back('{d: host.data_out, pe: host.par_err, fe: host.frm_err});
                got_t.push_back(cyc);
            end
            prev_dv = host.data_valid;
        end
    end

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic idle(input int bits);
        rx = 1'b1;
        repeat (bits * BIT_CLK) @(negedge clk);
    endtask

    // Send one frame and record what a correct receiver must report for it.
    task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic pe, input logic odd,
                              input logic pbit, input logic stop);
        int ones;
        logic exp_pe;
        par_en  = pe;
        par_odd = odd;
        send_bit(1'b0);
        for (int i = 0; i < int'(DATA_BITS); i++) send_bit(d[i]);
        if (pe) send_bit(pbit);
        send_bit(stop);
        ones   = $countones(d) + int'(pbit);
        exp_pe = pe && ((ones % 2) != int'(odd));
        exp_q.push_back('{d: d, pe: exp_pe, fe: !stop});
    endtask

    task automatic check_frames(input string tag);
        int n;
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_data"}, 32'(got_q[i].d), 32'(exp_q[i].d));
            check({tag, "_par_err"}, 32'(got_q[i].pe), 32'(exp_q[i].pe));
            check({tag, "_frm_err"}, 32'(got_q[i].fe), 32'(exp_q[i].fe));
        end
        got_q.delete();
        got_t.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [DATA_BITS-1:0] rd;
        logic                 rpe, rodd, rflip, rpbit;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(host.busy), 32'd0);
        check("rst_valid", 32'(host.data_valid), 32'd0);
        check("rst_data", 32'(host.data_out), 32'd0);
        check("rst_par_err", 32'(host.par_err), 32'd0);
        check("rst_frm_err", 32'(host.frm_err), 32'd0);
        rst = 1'b1;
        idle(2);

        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        check_frames("a5");

        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(2);
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(2);
        check_frames("parity");

        // Start glitch shorter than half a bit.
        rx = 1'b0;
        repeat (12) @(negedge clk);
        check("glitch_busy", 32'(host.busy), 32'd1);
        repeat (8) @(negedge clk);
        rx = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
        check("glitch_idle", 32'(host.busy), 32'd0);
        check_frames("glitch");

        // Framing error followed by a held-low line.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5 * BIT_CLK) @(negedge clk);
        check("break_busy", 32'(host.busy), 32'd1);
        check_frames("break");
        idle(1);
        check("break_released", 32'(host.busy), 32'd0);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        check_frames("after_break");

        // Back-to-back frames, no idle gap.
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        if (got_t.size() == 2) check("b2b_gap", 32'(got_t[1] - got_t[0]), 32'(10 * BIT_CLK));
        check_frames("b2b");

        // Reset in the middle of data bit 3.
        par_en = 1'b0;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rx = 1'b0;
        repeat (BIT_CLK / 2) @(negedge clk);
        check("mid_busy", 32'(host.busy), 32'd1);
        rst = 1'b0;
        #1;
        check("mrst_busy", 32'(host.busy), 32'd0);
        check("mrst_data", 32'(host.data_out), 32'd0);
        check("mrst_valid", 32'(host.data_valid), 32'd0);
        check("mrst_par_err", 32'(host.par_err), 32'd0);
        check("mrst_frm_err", 32'(host.frm_err), 32'd0);
        @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        idle(2);
        send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        check_frames("after_rst");

        // Random frames with random parity mode and occasionally corrupted parity bit.
        for (int k = 0; k < 10; k++) begin
            rd    = DATA_BITS'($urandom);
            rpe   = 1'($urandom_range(0, 1));
            rodd  = 1'($urandom_range(0, 1));
            rflip = ($urandom_range(0, 3) == 0);
            rpbit = 1'($countones(rd) % 2) ^ rodd ^ rflip;
            send_frame(rd, rpe, rodd, rpbit, 1'b1);
            if ($urandom_range(0, 1) == 1) idle(1);
        end
        idle(2);
        check_frames("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
UART receiver driven by the one-cycle baud tick from the baud rate generator. The tick runs at OVERSAMPLE x the bit rate. The block synchronises the serial input and detects the start bit with mid-bit validation. It samples data bits LSB-first, plus an optional parity bit and the stop bit, at bit centres. Each received frame is presented as a parallel word with a one-cycle valid strobe and error flags, for the UART host-side logic.

Parameters:
DATA_BITS, 8, payload bits per frame (5..9)
OVERSAMPLE, 16, tick pulses per bit period (even, >=4)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
tick  input  1  one-clk pulse from baud generator, OVERSAMPLE per bit
rx  input  1  serial line, idle high, asynchronous to clk
par_en  input  1  1 = frame carries a parity bit after the data bits
par_odd  input  1  1 = odd parity, 0 = even parity (used only when par_en=1)
data_out  output  DATA_BITS  last received word
data_valid  output  1  one-clk pulse, data_out and flags updated
par_err  output  1  parity mismatch on last frame
frm_err  output  1  stop bit sampled low on last frame
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst low, async): state=IDLE, tick counter=0, bit counter=0, shift reg=0, data_out=0, data_valid=0, par_err=0, frm_err=0, busy=0. Synchroniser FFs reset to 1.
- rx passes through a 2-FF synchroniser (rx_s). All decisions use rx_s and are taken only in cycles where tick=1. Cycles without tick hold all state.
- par_en and par_odd are sampled when leaving IDLE and held for the whole frame.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: on tick with rx_s=0 -> START, cnt=0.
- START: each tick cnt++. At cnt==OVERSAMPLE/2-1: if rx_s=0 -> DATA, cnt=0, bitn=0. Otherwise treat as glitch -> IDLE, with no output activity.
- DATA: each tick cnt++. At cnt==OVERSAMPLE-1: shift rx_s into the MSB of the shift reg (LSB-first line order), cnt=0, bitn++. After bit DATA_BITS-1 -> PARITY if par_en, else STOP.
- PARITY: at cnt==OVERSAMPLE-1, latch perr = rx_s XOR (XOR of data bits) XOR par_odd, cnt=0 -> STOP. The intent: even parity requires the total count of ones, including the parity bit, to be even.
- STOP: at cnt==OVERSAMPLE-1, load data_out and set frm_err=~rx_s and par_err=perr (0 if par_en=0). Pulse data_valid for exactly the next clk cycle. Go to IDLE if rx_s=1, else WAIT_HIGH.
- WAIT_HIGH (break / line held low): on tick with rx_s=1 -> IDLE. No new start is accepted until then.
- Output timing: data_valid rises on the clk edge after the stop-sample tick and lasts one clk. data_out, par_err and frm_err hold until the next frame completes.
- Back-to-back frames: the stop sample lands at the stop-bit centre. A start bit following immediately is detected from IDLE with half a bit of margin.
- tick held high continuously is legal (OVERSAMPLE=clk per bit).
- Reset mid-frame aborts the frame with no data_valid.

Test Plan:
- Setup: div=4 (tick every 4 clk), OVERSAMPLE=16, so 64 clk per bit. Send 0xA5, par_en=0, one stop bit -> single data_valid pulse, data_out=0xA5, par_err=0, frm_err=0.
- par_en=1, par_odd=0, send 0x07 with parity bit 1 -> data_out=0x07, par_err=0. Resend with parity bit 0 -> par_err=1.
- rx low pulse of 20 clk (less than half a bit) while IDLE -> back to IDLE, no data_valid, busy returns to 0.
- Send 0x3C with stop bit 0, then hold rx low for 5 bits -> data_valid pulses with data_out=0x3C and frm_err=1. A new frame of 0x81 is received only after rx returns high.
- Two frames sent back-to-back, 0x55 then 0xAA, with no idle gap -> two data_valid pulses 640 clk apart (10 bits x 64 clk), correct data each time.
- Assert rst during DATA bit 3 of a frame -> all outputs return to 0 immediately. A following 0x12 frame is received correctly.
